// File: rtl/id_stage_if.sv
// id_stage_if
//   Bundles the fetch-side, execute-side and writeback-side signals of the
//   decode / operand-fetch stage.
//   Handshake: fetch presents if_ir/if_pc with if_valid; when stall is high
//   in a cycle, fetch must present the same if_ir/if_pc (with if_valid) in
//   the next cycle. flush overrides stall and squashes the stage's slot.
//   master : driven by the surrounding pipeline (fetch, ALU, writeback)
//   slave  : the id_stage itself
//   Signals:
//     if_ir, if_pc, if_valid : instruction from fetch
//     stall                  : combinational hold request to fetch
//     flush                  : taken branch, squash this stage
//     ex_q                   : ALU registered result (instruction two slots back)
//     wb_we, wb_addr, wb_data: register-file write port
//     sr1, sr2, pc, ir       : registered operands / instruction to the ALU
interface id_stage_if;
    logic [15:0] if_ir;
    logic [15:0] if_pc;
    logic        if_valid;
    logic        stall;
    logic        flush;
    logic [15:0] ex_q;
    logic        wb_we;
    logic [2:0]  wb_addr;
    logic [15:0] wb_data;
    logic [15:0] sr1;
    logic [15:0] sr2;
    logic [15:0] pc;
    logic [15:0] ir;

    modport master (
        output if_ir, if_pc, if_valid, flush, ex_q, wb_we, wb_addr, wb_data,
        input  stall, sr1, sr2, pc, ir
    );

    modport slave (
        input  if_ir, if_pc, if_valid, flush, ex_q, wb_we, wb_addr, wb_data,
        output stall, sr1, sr2, pc, ir
    );
endinterface

// File: rtl/id_stage.sv
// id_stage
//   Decode / operand-fetch stage of the 16-bit pipelined CPU. Holds the
//   8x16 register file, latches the instruction from fetch and presents
//   registered sr1/sr2/pc/ir to the execute ALU.
//   Hazards: results of the instruction two slots back arrive on ex_q and
//   are forwarded, as is the writeback port; a dependency on the
//   instruction currently in ir costs exactly one bubble (stall).
//   Ports:
//     CLK  : clock, rising edge
//     RSTN : asynchronous active-low reset
//     bus  : id_stage_if.slave (fetch, flush, ex_q, writeback, ALU outputs)
module id_stage #(
    parameter int          NREG = 8,
    parameter logic [15:0] NOP  = 16'h0000
) (
    input  logic          CLK,
    input  logic          RSTN,
    id_stage_if.slave     bus
);

    localparam int RW = $clog2(NREG);

    // ADDi, ADD/CMP/MLT and LI write rd.
    function automatic logic writes_rd(input logic [15:0] x);
        logic r;
        r = 1'b0;
        case (x[15:14])
            2'b11:   r = 1'b1;
            2'b00:   r = (x[4:0] == 5'b00010) || (x[4:0] == 5'b00100) ||
                         (x[4:0] == 5'b00101);
            2'b01:   r = (x[10:8] == 3'b000);
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    // Branches carry their condition in bits 13:11: 010 = BZ, 001 = BNZ.
    function automatic logic uses_rs1(input logic [15:0] x);
        logic r;
        r = 1'b0;
        case (x[15:14])
            2'b11:   r = 1'b1;
            2'b00:   r = (x[4:0] == 5'b00010) || (x[4:0] == 5'b00100) ||
                         (x[4:0] == 5'b00101);
            2'b10:   r = (x[13:11] == 3'b010) || (x[13:11] == 3'b001);
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic uses_rs2(input logic [15:0] x);
        return (x[15:14] == 2'b00) &&
               ((x[4:0] == 5'b00010) || (x[4:0] == 5'b00100) ||
                (x[4:0] == 5'b00101));
    endfunction

    logic [15:0]   rf [NREG];
    logic [15:0]   ir_q;
    logic [15:0]   ir_d;
    logic [15:0]   sr1_q;
    logic [15:0]   sr2_q;
    logic [15:0]   pc_q;

    logic [RW-1:0] rs1_f;
    logic [RW-1:0] rs2_f;
    logic [RW-1:0] rd_ir;
    logic [RW-1:0] rd_ird;
    logic          hazard;
    logic          issue;
    logic [15:0]   op1;
    logic [15:0]   op2;

    assign rs1_f  = bus.if_ir[10:8];
    assign rs2_f  = bus.if_ir[7:5];
    assign rd_ir  = ir_q[13:11];
    assign rd_ird = ir_d[13:11];

    // The instruction in ir produces its result one cycle too late for the
    // instruction behind it, so that pairing needs a bubble. A flush wins.
    assign hazard = bus.if_valid && !bus.flush && writes_rd(ir_q) &&
                    ((rd_ir == rs1_f && uses_rs1(bus.if_ir)) ||
                     (rd_ir == rs2_f && uses_rs2(bus.if_ir)));

    assign bus.stall = RSTN && hazard;
    assign issue     = bus.if_valid && !hazard && !bus.flush;

    // Later assignments override earlier ones: register file, then the
    // writeback port, then ex_q as the newest value.
    always_comb begin
        op1 = rf[rs1_f];
        if (bus.wb_we && bus.wb_addr == rs1_f) op1 = bus.wb_data;
        if (writes_rd(ir_d) && rd_ird == rs1_f) op1 = bus.ex_q;

        op2 = rf[rs2_f];
        if (bus.wb_we && bus.wb_addr == rs2_f) op2 = bus.wb_data;
        if (writes_rd(ir_d) && rd_ird == rs2_f) op2 = bus.ex_q;
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            ir_q  <= '0;
            ir_d  <= '0;
            sr1_q <= '0;
            sr2_q <= '0;
            pc_q  <= '0;
            for (int i = 0; i < NREG; i++) rf[i] <= '0;
        end else begin
            ir_d <= ir_q;
            if (bus.wb_we) rf[bus.wb_addr] <= bus.wb_data;
            if (issue) begin
                ir_q  <= bus.if_ir;
                pc_q  <= bus.if_pc;
                sr1_q <= op1;
                sr2_q <= op2;
            end else begin
                ir_q  <= NOP;
                pc_q  <= '0;
                sr1_q <= '0;
                sr2_q <= '0;
            end
        end
    end

    assign bus.ir  = ir_q;
    assign bus.pc  = pc_q;
    assign bus.sr1 = sr1_q;
    assign bus.sr2 = sr2_q;

endmodule

// File: tb/tb_id_stage.sv
module tb_id_stage;

  logic CLK;
  logic RSTN;
  id_stage_if bus();

  id_stage #(.NREG(8), .NOP(16'h0000)) dut (
    .CLK  (CLK),
    .RSTN (RSTN),
    .bus  (bus.slave)
  );

  // ---------------- clock / reset ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ---------------- scoreboard state ----------------
  int          errors = 0;
  int          checks = 0;
  logic [63:0] exp_q[$];     // {sr1, sr2, pc, ir} expected after the next edge
  logic        stall_q[$];   // expected stall for the cycle just driven

  // Reference model: architectural registers and the issue history.
  logic [15:0] regs [8];
  logic [15:0] hist[$];      // hist[1] = last issued, hist[0] = the one before
  logic        held;
  logic [15:0] held_ir;
  logic [15:0] held_pc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_writes(input logic [15:0] x);
    bit [1:0] op = x[15:14];
    bit [4:0] fn = x[4:0];
    return (op == 2'd3) || (op == 2'd0 && (fn == 5'd2 || fn == 5'd4 || fn == 5'd5)) ||
           (op == 2'd1 && x[10:8] == 3'd0);
  endfunction

  function automatic bit m_alu3(input logic [15:0] x);
    return x[15:14] == 2'd0 && (x[4:0] == 5'd2 || x[4:0] == 5'd4 || x[4:0] == 5'd5);
  endfunction

  function automatic bit m_rs1(input logic [15:0] x);
    return x[15:14] == 2'd3 || m_alu3(x) ||
           (x[15:14] == 2'd2 && (x[13:11] == 3'd2 || x[13:11] == 3'd1));
  endfunction

  // Newest value of register r seen from the decode slot.
  function automatic logic [15:0] m_pick(input logic [2:0] r, input logic [15:0] older,
                                         input logic [15:0] xq, input logic we,
                                         input logic [2:0] wa, input logic [15:0] wd);
    if (m_writes(older) && older[13:11] == r) return xq;
    if (we && wa == r) return wd;
    return regs[r];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) regs[i] = 16'h0;
    hist = '{16'h0, 16'h0};
    held = 1'b0;
  endtask

  task automatic set_idle();
    bus.if_ir = 16'h0; bus.if_pc = 16'h0; bus.if_valid = 1'b0; bus.flush = 1'b0;
    bus.ex_q = 16'h0; bus.wb_we = 1'b0; bus.wb_addr = 3'd0; bus.wb_data = 16'h0;
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic [15:0] i_ir, input logic [15:0] i_pc, input logic v,
                      input logic f, input logic [15:0] xq, input logic we,
                      input logic [2:0] wa, input logic [15:0] wd);
    logic [15:0] prod, older, s1, s2;
    logic        hz;
    logic [63:0] e;
    @(posedge CLK); #2;
    bus.if_ir = i_ir; bus.if_pc = i_pc; bus.if_valid = v; bus.flush = f;
    bus.ex_q = xq; bus.wb_we = we; bus.wb_addr = wa; bus.wb_data = wd;
    #1;
    prod  = hist[1];
    older = hist[0];
    hz = v && !f && m_writes(prod) &&
         ((prod[13:11] == i_ir[10:8] && m_rs1(i_ir)) ||
          (prod[13:11] == i_ir[7:5] && m_alu3(i_ir)));
    stall_q.push_back(hz);
    s1 = m_pick(i_ir[10:8], older, xq, we, wa, wd);
    s2 = m_pick(i_ir[7:5], older, xq, we, wa, wd);
    e = (v && !hz && !f) ? {s1, s2, i_pc, i_ir} : 64'h0;
    exp_q.push_back(e);
    void'(hist.pop_front());
    hist.push_back(e[15:0]);
    if (we) regs[wa] = wd;
    held    = hz;
    held_ir = i_ir;
    held_pc = i_pc;
  endtask

  task automatic issue(input logic [15:0] i_ir, input logic [15:0] i_pc, input logic [15:0] xq);
    step(i_ir, i_pc, 1'b1, 1'b0, xq, 1'b0, 3'd0, 16'h0);
  endtask

  function automatic logic [15:0] rand_instr();
    logic [2:0] a, b, c;
    logic [4:0] fn;
    a  = 3'($urandom_range(0, 3));
    b  = 3'($urandom_range(0, 3));
    c  = 3'($urandom_range(0, 3));
    fn = 5'($urandom);
    case ($urandom_range(0, 7))
      0:       return {2'b11, a, b, 8'($urandom)};
      1, 2:    return {2'b00, a, b, c, (fn[0] ? 5'd2 : (fn[1] ? 5'd4 : 5'd5))};
      3:       return {2'b00, a, b, c, fn};
      4:       return {2'b01, a, 3'b000, 8'($urandom)};
      5:       return {2'b01, a, 3'($urandom_range(1, 7)), 8'($urandom)};
      6:       return {2'b10, 3'($urandom_range(0, 3)), b, 8'($urandom)};
      default: return 16'h0000;
    endcase
  endfunction

  // ---------------- monitor ----------------
  always @(negedge CLK) begin
    if (stall_q.size() > 0) chk("stall", {63'h0, bus.stall}, {63'h0, stall_q.pop_front()});
  end

  always @(posedge CLK) begin
    #1;
    if (exp_q.size() > 0) chk("sr1_sr2_pc_ir", {bus.sr1, bus.sr2, bus.pc, bus.ir}, exp_q.pop_front());
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [15:0] r_ir, r_pc;
    logic        r_v;
    RSTN = 1'b0;
    set_idle();
    model_reset();

    // Reset with random inputs: outputs zero, no stall.
    for (int i = 0; i < 5; i++) begin
      @(posedge CLK); #2;
      bus.if_ir = 16'($urandom); bus.if_pc = 16'($urandom); bus.if_valid = 1'b1;
      bus.flush = 1'b0; bus.ex_q = 16'($urandom); bus.wb_we = 1'b1;
      bus.wb_addr = 3'($urandom); bus.wb_data = 16'($urandom);
      #1;
      chk("reset_stall", {63'h0, bus.stall}, 64'h0);
      chk("reset_outputs", {bus.sr1, bus.sr2, bus.pc, bus.ir}, 64'h0);
    end
    set_idle();
    @(negedge CLK); RSTN = 1'b1;

    // Read of r5 after reset.
    issue(16'hC500, 16'h0001, 16'h0);
    // Writeback bypass into rs1 = 3.
    step(16'hC37F, 16'h0010, 1'b1, 1'b0, 16'h0, 1'b1, 3'd3, 16'h1234);
    // Back-to-back: LI r2,5 then ADD r1,r2,r2 -> one bubble, then forwarded.
    issue(16'h5005, 16'h0020, 16'h0);
    issue(16'h0A42, 16'h0021, 16'h0);
    issue(16'h0A42, 16'h0021, 16'h0005);
    // Distance-2 forwarding: LI r4,7; NOP; ADDi rs1=4 with ex_q = 7.
    issue(16'h6007, 16'h0030, 16'h0);
    issue(16'h0000, 16'h0031, 16'h0);
    issue(16'hCC00, 16'h0032, 16'h0007);
    // Flush beats a hazard.
    issue(16'h5005, 16'h0040, 16'h0);
    step(16'h0A42, 16'h0041, 1'b1, 1'b1, 16'h0, 1'b0, 3'd0, 16'h0);
    // ex_q beats writeback on r6; later plain read sees the written value.
    issue(16'h7011, 16'h0050, 16'h0);
    issue(16'h0000, 16'h0051, 16'h0);
    step(16'hC600, 16'h0052, 1'b1, 1'b0, 16'hAAAA, 1'b1, 3'd6, 16'h5555);
    issue(16'h0000, 16'h0053, 16'h0);
    issue(16'h0000, 16'h0054, 16'h0);
    issue(16'hC600, 16'h0055, 16'h0);

    // Reset while a stall is pending.
    issue(16'h5005, 16'h0060, 16'h0);
    issue(16'h0A42, 16'h0061, 16'h0);
    @(negedge CLK); #3;
    RSTN = 1'b0;
    #1;
    chk("midreset_stall", {63'h0, bus.stall}, 64'h0);
    chk("midreset_outputs", {bus.sr1, bus.sr2, bus.pc, bus.ir}, 64'h0);
    model_reset();
    set_idle();
    repeat (2) @(posedge CLK);
    @(negedge CLK); RSTN = 1'b1;
    issue(16'hC200, 16'h0070, 16'h0);

    // Randomized traffic; fetch honours stall by re-presenting the same slot.
    for (int n = 0; n < 1500; n++) begin
      if (held) begin
        r_ir = held_ir; r_pc = held_pc; r_v = 1'b1;
      end else begin
        r_ir = rand_instr(); r_pc = 16'($urandom); r_v = ($urandom_range(0, 9) != 0);
      end
      step(r_ir, r_pc, r_v, ($urandom_range(0, 15) == 0), 16'($urandom),
           ($urandom_range(0, 2) == 0), 3'($urandom_range(0, 7)), 16'($urandom));
    end

    repeat (3) @(posedge CLK);
    #2;
    chk("exp_q_drained", 64'(exp_q.size()), 64'h0);
    chk("stall_q_drained", 64'(stall_q.size()), 64'h0);

    // ---------------- final report ----------------
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- Decode / operand-fetch stage of the 16-bit pipelined CPU, directly upstream of the execute ALU.
- Holds the 8x16 register file and latches the instruction from fetch.
- Produces registered sr1, sr2, pc and ir for the ALU.
- Resolves data hazards in two ways:
  - forwarding the ALU result and the writeback port;
  - a one-cycle bubble for back-to-back dependencies.
- Squashes its own slot on a taken-branch flush.

Parameters:
- NREG, 8, number of architectural registers (register index width is 3).
- NOP, 16'h0000, bubble encoding; the ALU leaves q unchanged for it.

Ports:
- CLK  input  1  clock, rising edge.
- RSTN  input  1  asynchronous active-low reset.
- if_ir  input  16  instruction from fetch.
- if_pc  input  16  PC of if_ir.
- if_valid  input  1  if_ir/if_pc valid this cycle.
- stall  output  1  combinational; fetch must hold if_ir/if_pc next cycle.
- flush  input  1  taken branch; squash the instruction in this stage.
- ex_q  input  16  ALU registered result; belongs to the instruction issued two cycles earlier.
- wb_we  input  1  register-file write enable.
- wb_addr  input  3  write index.
- wb_data  input  16  write data.
- sr1  output  16  operand 1 = reg[ir[10:8]], registered.
- sr2  output  16  operand 2 = reg[ir[7:5]], registered.
- pc  output  16  PC of ir, registered.
- ir  output  16  issued instruction, registered.

Behaviour:
- Clock and reset:
  - Single clock CLK; reset is asynchronous and active-low (RSTN).
  - RSTN low clears sr1, sr2, pc and ir to 0, clears internal ir_d to 0, and clears all registers to 0.
  - Reset mid-operation discards any pending stall; stall is 0 while RSTN is low.
- Field decode:
  - rd = ir[13:11], rs1 = ir[10:8], rs2 = ir[7:5].
- writes_rd(x) is true for:
  - x[15:14]=11 (ADDi);
  - x[15:14]=00 with x[4:0] in {00010 ADD, 00100 CMP, 00101 MLT};
  - x[15:14]=01 with x[10:8]=000 (LI).
- uses_rs1(x) is true for ADDi, ADD, CMP, MLT, BZ (10_010) and BNZ (10_001).
- uses_rs2(x) is true for ADD, CMP and MLT. LI and B use no source.
- ir_d register: ir_d <= ir on every edge. ex_q is the result of ir_d.
- Hazard (stall), computed combinationally:
  - Condition: if_valid, no flush, writes_rd(ir), and rd(ir) equals rs1(if_ir) with uses_rs1, or rs2(if_ir) with uses_rs2.
  - Response: stall=1; next edge loads ir=NOP, sr1=sr2=pc=0; the held instruction issues on the following cycle.
  - Latency is exactly one bubble, never more.
- Operand selection per source, in priority order:
  - ex_q if writes_rd(ir_d) and rd(ir_d)==rs;
  - else wb_data if wb_we and wb_addr==rs;
  - else the register file.
  - Operands of unused sources are still selected this way; the value is don't-care, but no X is allowed.
- Normal issue: if_valid, no stall, no flush -> next edge ir<=if_ir, pc<=if_pc, sr1/sr2<=selected operands.
- if_valid=0 -> issue NOP with sr1=sr2=pc=0.
- flush=1:
  - Issues NOP next edge regardless of hazard.
  - Forces stall=0.
  - Fetch supplies the redirected stream.
- Register file:
  - Written on the rising edge when wb_we=1.
  - All 8 registers are writable; r0 is not hardwired.
  - Writes proceed during stall and flush.
- Simultaneous ex_q and wb matches on the same rs: ex_q wins (it is the newer result).

Test Plan:
- Reset: hold RSTN=0 with random inputs -> sr1, sr2, pc, ir = 0 and stall=0; after release, a read of r5 returns 0.
- Writeback bypass: wb_we=1, wb_addr=3, wb_data=16'h1234 while if_ir=ADDi rs1=3 (16'hC37F) -> next edge sr1=16'h1234, ir=16'hC37F.
- Back-to-back dependency:
  - Stimulus: LI r2,5 (16'h5005) then ADD r1,r2,r2 (16'h0A42).
  - Required: stall=1 for exactly one cycle and ir=0 in the bubble slot.
  - Next cycle: ADD issues with sr1=sr2=ex_q (driven 16'h0005).
- Distance-2 forwarding:
  - Stimulus: LI r4,7; NOP; ADDi with rs1=4; ex_q=16'h0007 and a stale register file.
  - Required: sr1=16'h0007 with no stall.
- Flush priority: hazard present and flush=1 in the same cycle -> stall=0, next ir=0, pc=0.
- Priority conflict: ex_q=16'hAAAA for rd=6, plus wb_we writing r6 with 16'h5555, then an ADDi rs1=6 issues -> sr1=16'hAAAA; a later read of r6 (no forwarding) = 16'h5555.
